in_debounce: RTL and testbench

//  Input conditioner sitting directly upstream of the serial-bit FSM: takes a raw,

---
 rtl/in_debounce.sv | 131 +++++++++++++
 tb/tb_in_debounce.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/in_debounce.sv
// Input conditioner: synchroniser chain, 4-state debounce FSM and stability counter.
// Optional rise_o/fall_o edge pulses are built when IN_DEBOUNCE_EDGE_EN is defined.
module in_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic out_o
`ifdef IN_DEBOUNCE_EDGE_EN
  ,
  output logic rise_o,
  output logic fall_o
`endif
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'b00,
    CHECK_HIGH  = 2'b01,
    HIGH_STABLE = 2'b10,
    CHECK_LOW   = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_q, out_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= LOW_STABLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // cnt holds the number of consecutive candidate samples already seen
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      LOW_STABLE: begin
        if (s) begin
          state_d = CHECK_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      CHECK_HIGH: begin
        if (!s) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH_STABLE;
          out_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH_STABLE: begin
        if (!s) begin
          state_d = CHECK_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      CHECK_LOW: begin
        if (s) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW_STABLE;
          out_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = LOW_STABLE;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase
  end

  assign out_o = out_q;

`ifdef IN_DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  // Pulses register alongside out_q so they coincide with its first new-value cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= out_d & ~out_q;
      fall_q <= ~out_d & out_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`endif

endmodule

// File: tb/tb_in_debounce.sv
// Directed, table-driven bench for in_debounce (defaults SYNC_STAGES=2, DEBOUNCE_CYCLES=16).
module tb_in_debounce;

  logic clk_i;
  logic rst_i;
  logic raw_i;
  logic out_o;
`ifdef IN_DEBOUNCE_EDGE_EN
  logic rise_o;
  logic fall_o;
`endif

  int unsigned n_tests;
  int unsigned n_fail;

  in_debounce #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .raw_i (raw_i),
    .out_o (out_o)
`ifdef IN_DEBOUNCE_EDGE_EN
    ,
    .rise_o(rise_o),
    .fall_o(fall_o)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic        raw;
    int unsigned edges;
    logic        out;
    logic        rise;
    logic        fall;
  } vec_t;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string name, input logic e_out, input logic e_rise,
                            input logic e_fall);
    check_bit({name, " out_o"}, out_o, e_out);
`ifdef IN_DEBOUNCE_EDGE_EN
    check_bit({name, " rise_o"}, rise_o, e_rise);
    check_bit({name, " fall_o"}, fall_o, e_fall);
`else
    if (e_rise || e_fall) begin
    end
`endif
  endtask

  vec_t vecs[$];

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Edge counts are taken from the first edge that samples the new raw_i.
    // Release with raw_i=1: change on edge 18
    vecs.push_back('{1'b1, 17, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1,  1'b1, 1'b0, 1'b0});
    // Back to low
    vecs.push_back('{1'b0, 17, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1,  1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1,  1'b0, 1'b0, 1'b0});
    // High for only 15 cycles: rejected
    vecs.push_back('{1'b1, 15, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 5,  1'b0, 1'b0, 1'b0});
    // High 16+ cycles: accepted on edge 18
    vecs.push_back('{1'b1, 17, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 10, 1'b1, 1'b0, 1'b0});
    // Low 5, high 3, low 20: falls 18 edges after final fall
    vecs.push_back('{1'b0, 5,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 3,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 17, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1,  1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 5,  1'b0, 1'b0, 1'b0});

    // Reset held low 3 cycles with raw_i=1
    rst_i = 1'b0;
    raw_i = 1'b1;
    #1;
    check_outs("reset_immediate", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs("reset_hold", 1'b0, 1'b0, 1'b0);
    end
    rst_i = 1'b1;

    for (int v = 0; v < vecs.size(); v++) begin
      raw_i = vecs[v].raw;
      for (int unsigned e = 0; e < vecs[v].edges; e++) tick();
      check_outs($sformatf("vec%0d", v), vecs[v].out, vecs[v].rise, vecs[v].fall);
    end

    // Toggling every cycle never qualifies
    for (int i = 0; i < 100; i++) begin
      raw_i = ~raw_i;
      tick();
      check_outs("toggle", 1'b0, 1'b0, 1'b0);
    end

    // Qualify high, then reset mid CHECK_LOW
    raw_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check_outs("pre_mid_reset_high", 1'b1, 1'b0, 1'b0);
    raw_i = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check_outs("in_check_low", 1'b1, 1'b0, 1'b0);
    rst_i = 1'b0;
    #1;
    check_outs("mid_check_reset", 1'b0, 1'b0, 1'b0);
    rst_i = 1'b1;
    raw_i = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    check_outs("requalify_17", 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("requalify_18", 1'b1, 1'b1, 1'b0);
    tick();
    check_outs("requalify_19", 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
